// File: rtl/mem_copy_pkg.sv
// Shared types and default widths for the memory copy engine.
package mem_copy_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 16;
    localparam int BANK_BIT   = 14;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Command and memory-bus signals of the copy engine; master = engine side, slave = host/memory side.
interface mem_copy_engine_if
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W-1:0] count;
    logic              busy;
    logic              done;
    logic              mem_enable;
    logic              mem_write_enable;
    logic              mem_read_enable;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  start, src_addr, dst_addr, count, mem_rdata,
        output busy, done, mem_enable, mem_write_enable, mem_read_enable,
               mem_address, mem_wdata
    );

    modport slave (
        output start, src_addr, dst_addr, count, mem_rdata,
        input  busy, done, mem_enable, mem_write_enable, mem_read_enable,
               mem_address, mem_wdata
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine (read, wait, write per word) with registered bus outputs.
// Build option: define MEM_COPY_INVERT_EN to write the bitwise complement of each copied word.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
)
(
    input  logic               clk,
    input  logic               rst,
    mem_copy_engine_if.master  bus
);

    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data_q;

    logic              busy_q;
    logic              done_q;
    logic              en_q;
    logic              we_q;
    logic              re_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [ADDR_W:0]   idx_inc;
    logic              more_words;
    logic [DATA_W-1:0] word_out;

    // One extra bit so the "another word left" compare cannot overflow.
    assign idx_inc    = {1'b0, idx} + (ADDR_W+1)'(1);
    assign more_words = idx_inc < {1'b0, cnt_q};

`ifdef MEM_COPY_INVERT_EN
    assign word_out = ~bus.mem_rdata;
`else
    assign word_out = bus.mem_rdata;
`endif

    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.mem_enable       = en_q;
    assign bus.mem_write_enable = we_q;
    assign bus.mem_read_enable  = re_q;
    assign bus.mem_address      = addr_q;
    assign bus.mem_wdata        = wdata_q;

    // Outputs are registered, so each transition loads the strobes of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            idx     <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    busy_q <= 1'b0;
                    en_q   <= 1'b0;
                    we_q   <= 1'b0;
                    re_q   <= 1'b0;
                    if (bus.start) begin
                        src_q <= bus.src_addr;
                        dst_q <= bus.dst_addr;
                        cnt_q <= bus.count;
                        idx   <= '0;
                        if (bus.count == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= READ;
                            busy_q <= 1'b1;
                            en_q   <= 1'b1;
                            re_q   <= 1'b1;
                            addr_q <= bus.src_addr;
                        end
                    end
                end
                READ: begin
                    state  <= WAIT;
                    en_q   <= 1'b0;
                    re_q   <= 1'b0;
                    addr_q <= '0;
                end
                WAIT: begin
                    data_q  <= bus.mem_rdata;
                    wdata_q <= word_out;
                    state   <= WRITE;
                    en_q    <= 1'b1;
                    we_q    <= 1'b1;
                    addr_q  <= dst_q + idx;
                end
                WRITE: begin
                    idx     <= idx_inc[ADDR_W-1:0];
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                    if (more_words) begin
                        state  <= READ;
                        re_q   <= 1'b1;
                        addr_q <= src_q + idx_inc[ADDR_W-1:0];
                    end else begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        en_q   <= 1'b0;
                        addr_q <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    en_q   <= 1'b0;
                    we_q   <= 1'b0;
                    re_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine: table-driven copies, scoreboarded memory traffic, corner sequences.
module tb_mem_copy_engine;
    import mem_copy_pkg::*;

    localparam int AW = 15;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_copy_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    logic          pl_we   = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic [AW-1:0] rd_q[$];
    wr_t           wr_q[$];

    // Synchronous RAM: read data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (pl_we)
            mem[pl_addr] <= pl_data;
        else if (bus.mem_enable && bus.mem_write_enable)
            mem[bus.mem_address] <= bus.mem_wdata;
        if (bus.mem_enable && bus.mem_read_enable)
            bus.mem_rdata <= mem[bus.mem_address];
        else
            bus.mem_rdata <= 16'hBAD0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Bus monitor: every strobe must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            chk("strobe_overlap", {31'd0, bus.mem_read_enable & bus.mem_write_enable}, 32'd0);
            if (bus.mem_enable && !bus.mem_read_enable && !bus.mem_write_enable)
                chk("enable_without_strobe", 32'd1, 32'd0);
            if (bus.mem_read_enable) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_read", {17'd0, bus.mem_address}, 32'hFFFFFFFF);
                end else begin
                    logic [AW-1:0] a;
                    a = rd_q.pop_front();
                    chk("read_enable", {31'd0, bus.mem_enable}, 32'd1);
                    chk("read_addr", {17'd0, bus.mem_address}, {17'd0, a});
                end
            end
            if (bus.mem_write_enable) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", {17'd0, bus.mem_address}, 32'hFFFFFFFF);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("write_enable", {31'd0, bus.mem_enable}, 32'd1);
                    chk("write_addr", {17'd0, bus.mem_address}, {17'd0, w.addr});
                    chk("write_data", {16'd0, bus.mem_wdata}, {16'd0, w.data});
                end
            end
        end
    end

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic model_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int n);
        for (int k = 0; k < n; k++) begin
            logic [AW-1:0] ra, wa;
            logic [DW-1:0] d, wd;
            wr_t w;
            ra = src + AW'(k);
            wa = dst + AW'(k);
            d  = ref_mem[ra];
`ifdef MEM_COPY_INVERT_EN
            wd = ~d;
`else
            wd = d;
`endif
            ref_mem[wa] = wd;
            rd_q.push_back(ra);
            w.addr = wa;
            w.data = wd;
            wr_q.push_back(w);
        end
    endtask

    task automatic outputs_zero(input string nm);
        chk({nm, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({nm, "_done"}, {31'd0, bus.done}, 32'd0);
        chk({nm, "_strobes"}, {29'd0, bus.mem_enable, bus.mem_read_enable, bus.mem_write_enable}, 32'd0);
        chk({nm, "_addr"}, {17'd0, bus.mem_address}, 32'd0);
        chk({nm, "_wdata"}, {16'd0, bus.mem_wdata}, 32'd0);
    endtask

    // Issue one copy; optionally pulse start again mid-copy; check latency, busy span, pulse width, result.
    task automatic run_copy(input string nm, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                            input logic [AW-1:0] cnt, input int exp_lat, input logic poke);
        int lat, busy_cyc;
        model_copy(src, dst, int'(cnt));
        bus.start    = 1'b1;
        bus.src_addr = src;
        bus.dst_addr = dst;
        bus.count    = cnt;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.src_addr = 15'h5A5A;
        bus.dst_addr = 15'h2A2A;
        lat      = 1;
        busy_cyc = 0;
        while (!bus.done && lat < exp_lat + 8) begin
            if (bus.busy) busy_cyc++;
            if (poke && lat == 2) begin
                bus.start    = 1'b1;
                bus.src_addr = 15'h1234;
                bus.dst_addr = 15'h0040;
                bus.count    = 15'd7;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        chk({nm, "_done_seen"}, {31'd0, bus.done}, 32'd1);
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_busy_cycles"}, busy_cyc, 3 * int'(cnt));
        chk({nm, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        chk({nm, "_done_width"}, {31'd0, bus.done}, 32'd0);
        chk({nm, "_rd_q_empty"}, rd_q.size(), 0);
        chk({nm, "_wr_q_empty"}, wr_q.size(), 0);
        for (int k = 0; k < int'(cnt); k++) begin
            logic [AW-1:0] wa;
            wa = dst + AW'(k);
            chk({nm, "_mem"}, {16'd0, mem[wa]}, {16'd0, ref_mem[wa]});
        end
        rd_q.delete();
        wr_q.delete();
    endtask

    typedef struct {
        string         name;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [AW-1:0] cnt;
        logic [DW-1:0] base;
        int            exp_lat;
        logic          poke;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{"basic4",      15'h4000, 15'h0010, 15'd4, 16'h1111,  13, 1'b0};
        vecs[1] = '{"count0",      15'h1000, 15'h1100, 15'd0, 16'h0000,   1, 1'b0};
        vecs[2] = '{"src_wrap",    15'h7FFE, 15'h2000, 15'd3, 16'h0000,  10, 1'b0};
        vecs[3] = '{"overlap_fwd", 15'h0100, 15'h0101, 15'd5, 16'h0000,  16, 1'b0};
        vecs[4] = '{"dst_wrap",    15'h0300, 15'h7FFF, 15'd2, 16'h0000,   7, 1'b0};
        vecs[5] = '{"single",      15'h0400, 15'h4400, 15'd1, 16'h0000,   4, 1'b0};
        vecs[6] = '{"start_busy",  15'h0A00, 15'h0B00, 15'd3, 16'h0000,  10, 1'b1};

        bus.start    = 1'b0;
        bus.src_addr = '0;
        bus.dst_addr = '0;
        bus.count    = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < int'(vecs[v].cnt); k++) begin
                logic [DW-1:0] d;
                d = (vecs[v].base != 0) ? DW'((k + 1) * int'(vecs[v].base)) : DW'($urandom);
                preload(vecs[v].src + AW'(k), d);
            end
            run_copy(vecs[v].name, vecs[v].src, vecs[v].dst, vecs[v].cnt, vecs[v].exp_lat, vecs[v].poke);
        end

        for (int k = 0; k < 4; k++)
            chk("basic4_const", {16'd0, mem[15'h0010 + AW'(k)]},
`ifdef MEM_COPY_INVERT_EN
                {16'd0, ~DW'((k + 1) * 16'h1111)});
`else
                {16'd0, DW'((k + 1) * 16'h1111)});
`endif

        preload(15'h0700, 16'h00FF);
        run_copy("invert_word", 15'h0700, 15'h0800, 15'd1, 4, 1'b0);
`ifdef MEM_COPY_INVERT_EN
        chk("invert_const", {16'd0, mem[15'h0800]}, 32'h0000FF00);
`else
        chk("invert_const", {16'd0, mem[15'h0800]}, 32'h000000FF);
`endif

        // Abort during WAIT of the second word: only word 1 may reach memory.
        for (int k = 0; k < 4; k++)
            preload(15'h0500 + AW'(k), 16'hC000 + DW'(k));
        preload(15'h0601, 16'hDEAD);
        model_copy(15'h0500, 15'h0600, 1);
        rd_q.push_back(15'h0501);
        bus.start    = 1'b1;
        bus.src_addr = 15'h0500;
        bus.dst_addr = 15'h0600;
        bus.count    = 15'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        outputs_zero("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        begin
            int done_cnt;
            done_cnt = 0;
            repeat (15) begin
                @(posedge clk); #1;
                if (bus.done) done_cnt++;
            end
            chk("abort_no_done", done_cnt, 0);
        end
        chk("abort_rd_q_empty", rd_q.size(), 0);
        chk("abort_wr_q_empty", wr_q.size(), 0);
        chk("abort_word1", {16'd0, mem[15'h0600]}, {16'd0, ref_mem[15'h0600]});
        chk("abort_word2_untouched", {16'd0, mem[15'h0601]}, 32'h0000DEAD);
        rd_q.delete();
        wr_q.delete();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 15, word-address width; DATA_W, default 16, data word width.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 start  in  1  one-cycle request pulse to begin a copy.
REQ-005 src_addr  in  ADDR_W  first source word address; bit 14 selects bank.
REQ-006 dst_addr  in  ADDR_W  first destination word address; bit 14 selects bank.
REQ-007 count  in  ADDR_W  number of words to copy.
REQ-008 busy  out  1  high while a copy is in progress.
REQ-009 done  out  1  one-cycle pulse when a copy completes.
REQ-010 mem_enable  out  1  memory enable.
REQ-011 mem_write_enable  out  1  memory write strobe.
REQ-012 mem_read_enable  out  1  memory read strobe.
REQ-013 mem_address  out  ADDR_W  memory word address.
REQ-014 mem_wdata  out  DATA_W  data to memory input_data.
REQ-015 mem_rdata  in  DATA_W  data from memory output_data, valid exactly one cycle after a read strobe.

Function
REQ-016 FSM states SHALL be IDLE, READ, WAIT, WRITE, DONE.
REQ-017 In IDLE, start=1 SHALL latch src_addr, dst_addr, count and clear word index i; next state READ, or DONE if count==0.
REQ-018 start SHALL be ignored in every state other than IDLE.
REQ-019 READ: mem_enable=1, mem_read_enable=1, mem_write_enable=0, mem_address=src+i; next WAIT.
REQ-020 WAIT: all strobes 0; mem_rdata SHALL be captured into a data register at end of cycle; next WRITE.
REQ-021 WRITE: mem_enable=1, mem_write_enable=1, mem_read_enable=0, mem_address=dst+i, mem_wdata=captured word; i increments; next READ if i+1<count, else DONE.
REQ-022 DONE: done=1 for exactly one cycle, strobes 0; next IDLE.
REQ-023 busy SHALL be 1 in READ, WAIT, WRITE and 0 in IDLE and DONE.
REQ-024 Throughput SHALL be 3 cycles per word; a copy of N>0 words SHALL assert done 3N+1 cycles after the start cycle.
REQ-025 Address sums SHALL be computed modulo 2^ADDR_W (0x7FFF+1 wraps to 0x0000, crossing banks).
REQ-026 Copy order SHALL be ascending i; overlapping ranges yield forward-copy semantics.
REQ-027 read and write strobes SHALL never be high in the same cycle.

Reset
REQ-028 rst=1 SHALL force IDLE and zero busy, done, all strobes, mem_address, mem_wdata, index and data register next cycle.
REQ-029 rst during a copy SHALL abort it with no further memory writes and no done pulse.

Configuration
REQ-030 With MEM_COPY_INVERT_EN defined, mem_wdata in WRITE SHALL be the bitwise complement of the captured word; without it, the captured word unchanged.

Structure
REQ-031 Package mem_copy_pkg SHALL hold the FSM state enum and ADDR_W/DATA_W default constants.
REQ-032 No sub-module; a single flat module with one FSM and one datapath.

Verification
REQ-033 Preload src 0x4000..0x4003 = 0x1111,0x2222,0x3333,0x4444; start src=0x4000 dst=0x0010 count=4 -> dst 0x0010..0x0013 hold same words, done at cycle 13 after start.
REQ-034 start with count=0 -> no strobe asserted, done pulses the cycle after start, busy stays 0.
REQ-035 src=0x7FFE count=3 -> reads 0x7FFE, 0x7FFF, 0x0000 in order.
REQ-036 start pulsed again during busy -> ignored; original copy completes unchanged.
REQ-037 rst asserted in WAIT of word 2 of count=4 -> only word 1 written, no done, all outputs 0 next cycle.
REQ-038 With MEM_COPY_INVERT_EN, copy of 0x00FF -> destination holds 0xFF00.
